// File: rtl/nal_chunk_scheduler.sv
// nal_chunk_scheduler
// Round-robin arbiter that lends one NAL unit detector to several camera
// chunk sources. A granted chunk is latched, announced with a one-cycle
// det_chunk_valid pulse and held until the detector reports completion or a
// watchdog gives up on it. Detector NAL events are re-registered and tagged
// with the ID of the stream that owns the detector.

`timescale 1ns/1ps

module nal_chunk_scheduler #(
   parameter int NUM_STREAMS = 4,
   parameter int CHUNK_W     = 3072,
   parameter int TIMEOUT     = 1023,
   parameter int SW          = $clog2(NUM_STREAMS)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_STREAMS*CHUNK_W-1:0] req_chunk,
   input  logic [NUM_STREAMS-1:0]         req_valid,
   output logic [NUM_STREAMS-1:0]         req_ready,
   output logic [CHUNK_W-1:0]             det_chunk_data,
   output logic                           det_chunk_valid,
   input  logic                           det_done,
   input  logic                           det_nal_start,
   input  logic                           det_nal_end,
   output logic                           nal_start_out,
   output logic                           nal_end_out,
   output logic [SW-1:0]                  nal_stream_id,
   output logic [SW-1:0]                  grant_id,
   output logic                           busy,
   output logic                           timeout_err,
   output logic [15:0]                    chunks_issued
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // Watchdog only has to count up to TIMEOUT-1 before it fires.
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [1:0]         state_reg;
   logic [SW-1:0]      last_grant_reg;
   logic [SW-1:0]      grant_id_reg;
   logic [CHUNK_W-1:0] det_chunk_data_reg;
   logic [WD_W-1:0]    wd_reg;
   logic [15:0]        chunks_issued_reg;
   logic               timeout_err_reg;
   logic               nal_start_reg;
   logic               nal_end_reg;
   logic [SW-1:0]      nal_stream_id_reg;

   logic [SW-1:0]      cand_idx [NUM_STREAMS];
   logic               sel_valid;
   logic [SW-1:0]      sel_idx;

   // Search order: the stream after the last one served comes first, so the
   // stream just served is always last in line.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_cand
         assign cand_idx[gi] = SW'((int'(last_grant_reg) + 1 + gi) % NUM_STREAMS);
      end
   endgenerate

   // Pick the first requesting stream in rotated order (lowest position wins).
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_STREAMS - 1; k >= 0; k--) begin
         if (req_valid[cand_idx[k]]) begin
            sel_valid = 1'b1;
            sel_idx   = cand_idx[k];
         end
      end
   end

   // One-hot ready, only offered while idle and never while reset is held.
   generate
      for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_ready
         assign req_ready[gi] = reset_n && (state_reg == ST_IDLE) && sel_valid
                                && (sel_idx == SW'(gi));
      end
   endgenerate

   // Scheduler FSM: accept a chunk, announce it, then wait for done or timeout.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg          <= ST_IDLE;
         last_grant_reg     <= SW'(NUM_STREAMS - 1);
         grant_id_reg       <= '0;
         det_chunk_data_reg <= '0;
         wd_reg             <= '0;
         chunks_issued_reg  <= '0;
         timeout_err_reg    <= 1'b0;
      end else begin
         timeout_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (sel_valid) begin
                  det_chunk_data_reg <= req_chunk[sel_idx*CHUNK_W +: CHUNK_W];
                  grant_id_reg       <= sel_idx;
                  state_reg          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               chunks_issued_reg <= chunks_issued_reg + 16'd1;
               wd_reg            <= '0;
               state_reg         <= ST_WAIT;
            end
            ST_WAIT: begin
               wd_reg <= wd_reg + WD_W'(1);
               // det_done takes priority over a watchdog expiring in the same cycle.
               if (det_done) begin
                  last_grant_reg <= grant_id_reg;
                  state_reg      <= ST_IDLE;
               end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                  timeout_err_reg <= 1'b1;
                  last_grant_reg  <= grant_id_reg;
                  state_reg       <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Re-register detector NAL events and tag them with the current owner.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nal_start_reg     <= 1'b0;
         nal_end_reg       <= 1'b0;
         nal_stream_id_reg <= '0;
      end else begin
         nal_start_reg     <= det_nal_start;
         nal_end_reg       <= det_nal_end;
         nal_stream_id_reg <= grant_id_reg;
      end
   end

   assign det_chunk_data  = det_chunk_data_reg;
   assign det_chunk_valid = (state_reg == ST_ISSUE);
   assign busy            = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
   assign grant_id        = grant_id_reg;
   assign timeout_err     = timeout_err_reg;
   assign chunks_issued   = chunks_issued_reg;
   assign nal_start_out   = nal_start_reg;
   assign nal_end_out     = nal_end_reg;
   assign nal_stream_id   = nal_stream_id_reg;

endmodule

// File: tb/tb_nal_chunk_scheduler.sv
// Directed testbench for nal_chunk_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge.

`timescale 1ns/1ps

module tb_nal_chunk_scheduler;

   localparam int N  = 4;
   localparam int CW = 3072;
   localparam int TO = 1023;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N*CW-1:0] req_chunk;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [CW-1:0]   det_chunk_data;
   logic            det_chunk_valid;
   logic            det_done;
   logic            det_nal_start;
   logic            det_nal_end;
   logic            nal_start_out;
   logic            nal_end_out;
   logic [SW-1:0]   nal_stream_id;
   logic [SW-1:0]   grant_id;
   logic            busy;
   logic            timeout_err;
   logic [15:0]     chunks_issued;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nal_chunk_scheduler #(
      .NUM_STREAMS(N),
      .CHUNK_W(CW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_chunk(req_chunk),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .det_chunk_data(det_chunk_data),
      .det_chunk_valid(det_chunk_valid),
      .det_done(det_done),
      .det_nal_start(det_nal_start),
      .det_nal_end(det_nal_end),
      .nal_start_out(nal_start_out),
      .nal_end_out(nal_end_out),
      .nal_stream_id(nal_stream_id),
      .grant_id(grant_id),
      .busy(busy),
      .timeout_err(timeout_err),
      .chunks_issued(chunks_issued)
   );

   // Distinct, recognisable chunk pattern per stream.
   function automatic logic [CW-1:0] pat(input int s);
      logic [CW-1:0] v;
      for (int w = 0; w < CW / 32; w++) begin
         v[w*32 +: 32] = 32'hC0DE0000 ^ 32'(s << 12) ^ 32'(w);
      end
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      req_valid     = '0;
      det_done      = 1'b0;
      det_nal_start = 1'b0;
      det_nal_end   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Advance until det_chunk_valid is seen (bounded); prints the transaction.
   task automatic wait_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (det_chunk_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (ok)
         $display("issue stream=%0d chunks_before=%0d t=%0t", grant_id, chunks_issued, $time);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (det_chunk_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", det_chunk_valid); end
      checks++; if (det_chunk_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", det_chunk_data[31:0]); end
      checks++; if (chunks_issued !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", chunks_issued); end
      checks++; if (grant_id !== 2'd0 || nal_stream_id !== 2'd0) begin failures++; $display("FAIL reset_ids: got %0d/%0d want 0/0", grant_id, nal_stream_id); end
      checks++; if (timeout_err !== 1'b0 || nal_start_out !== 1'b0 || nal_end_out !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %b%b%b want 000", timeout_err, nal_start_out, nal_end_out); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
   endtask

   task automatic test_single();
      bit ok;
      int bad;
      do_reset();
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      tick();
      wait_issue(ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_issue: got no det_chunk_valid want pulse"); end
      checks++; if (grant_id !== 2'd0 || busy !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL single_issue_state: got grant=%0d busy=%b ready=%b want 0/1/0000", grant_id, busy, req_ready); end
      req_valid = 4'b0000;
      bad = 0;
      for (int i = 1; i <= 386; i++) begin
         tick();
         if (det_chunk_data !== pat(0) || det_chunk_valid !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL single_hold: got %0d bad WAIT cycles want 0", bad); end
      checks++; if (chunks_issued !== 16'd1) begin failures++; $display("FAIL single_count: got %0d want 1", chunks_issued); end
      det_done = 1'b1;
      tick();
      det_done = 1'b0;
      checks++; if (busy !== 1'b0 || det_chunk_valid !== 1'b0) begin failures++; $display("FAIL single_done: got busy=%b valid=%b want 0/0", busy, det_chunk_valid); end
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_g;
      int prev;
      logic [N-1:0] exp_rdy;
      do_reset();
      req_valid = 4'b1111;
      prev = -1;
      for (int g = 0; g < 6; g++) begin
         exp_g = g % N;
         wait_issue(ok);
         checks++; if (!ok) begin failures++; $display("FAIL rr_issue%0d: got no det_chunk_valid want pulse", g); end
         checks++; if (int'(grant_id) != exp_g || int'(grant_id) == prev) begin failures++; $display("FAIL rr_grant%0d: got %0d want %0d", g, grant_id, exp_g); end
         checks++; if (det_chunk_data !== pat(exp_g)) begin failures++; $display("FAIL rr_data%0d: got %h want %h", g, det_chunk_data[31:0], pat(exp_g) & 32'hFFFFFFFF); end
         prev = int'(grant_id);
         repeat (10) tick();
         det_done = 1'b1;
         tick();
         det_done = 1'b0;
         exp_rdy = 4'b0001 << ((g + 1) % N);
         checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready%0d: got %b want %b", g, req_ready, exp_rdy); end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_tagging();
      bit ok;
      do_reset();
      req_valid = 4'b0100;
      wait_issue(ok);
      checks++; if (!ok || grant_id !== 2'd2) begin failures++; $display("FAIL tag_grant: got %0d want 2", grant_id); end
      req_valid = 4'b0000;
      tick();
      det_nal_start = 1'b1;
      tick();
      det_nal_start = 1'b0;
      checks++; if (nal_start_out !== 1'b1 || nal_end_out !== 1'b0 || nal_stream_id !== 2'd2) begin failures++; $display("FAIL tag_start: got s=%b e=%b id=%0d want 1/0/2", nal_start_out, nal_end_out, nal_stream_id); end
      det_nal_end = 1'b1;
      tick();
      det_nal_end = 1'b0;
      checks++; if (nal_end_out !== 1'b1 || nal_start_out !== 1'b0 || nal_stream_id !== 2'd2) begin failures++; $display("FAIL tag_end: got s=%b e=%b id=%0d want 0/1/2", nal_start_out, nal_end_out, nal_stream_id); end
      tick();
      checks++; if (nal_end_out !== 1'b0) begin failures++; $display("FAIL tag_end_width: got %b want 0", nal_end_out); end
      det_nal_end = 1'b1;
      det_done    = 1'b1;
      tick();
      det_nal_end = 1'b0;
      det_done    = 1'b0;
      checks++; if (nal_end_out !== 1'b1 || nal_stream_id !== 2'd2 || busy !== 1'b0) begin failures++; $display("FAIL tag_end_done: got e=%b id=%0d busy=%b want 1/2/0", nal_end_out, nal_stream_id, busy); end
      det_nal_start = 1'b1;
      tick();
      det_nal_start = 1'b0;
      checks++; if (nal_start_out !== 1'b1 || nal_stream_id !== 2'd2) begin failures++; $display("FAIL tag_idle: got s=%b id=%0d want 1/2", nal_start_out, nal_stream_id); end
   endtask

   task automatic test_watchdog();
      bit ok;
      int early;
      do_reset();
      req_valid = 4'b0001;
      wait_issue(ok);
      checks++; if (!ok || grant_id !== 2'd0) begin failures++; $display("FAIL wd_grant0: got %0d want 0", grant_id); end
      req_valid = 4'b0011;
      early = 0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (timeout_err !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) early++;
      end
      checks++; if (early != 0) begin failures++; $display("FAIL wd_early: got %0d bad cycles want 0", early); end
      tick();
      checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wd_fire: got err=%b busy=%b want 1/0", timeout_err, busy); end
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wd_next_ready: got %b want 0010", req_ready); end
      tick();
      req_valid = 4'b0000;
      checks++; if (timeout_err !== 1'b0 || grant_id !== 2'd1 || det_chunk_valid !== 1'b1) begin failures++; $display("FAIL wd_next: got err=%b grant=%0d valid=%b want 0/1/1", timeout_err, grant_id, det_chunk_valid); end
      for (int k = 1; k <= TO; k++) tick();
      det_done = 1'b1;
      tick();
      det_done = 1'b0;
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL wd_tie: got err=%b busy=%b want 0/0", timeout_err, busy); end
      tick();
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL wd_tie_late: got %b want 0", timeout_err); end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      do_reset();
      req_valid = 4'b0010;
      wait_issue(ok);
      checks++; if (!ok || grant_id !== 2'd1) begin failures++; $display("FAIL rst_grant1: got %0d want 1", grant_id); end
      req_valid = 4'b0000;
      repeat (5) tick();
      reset_n       = 1'b0;
      req_valid     = 4'b1111;
      det_nal_start = 1'b1;
      det_nal_end   = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || det_chunk_valid !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rst_state: got busy=%b valid=%b ready=%b want 0/0/0000", busy, det_chunk_valid, req_ready); end
      checks++; if (det_chunk_data !== '0 || chunks_issued !== 16'd0) begin failures++; $display("FAIL rst_data: got data=%h count=%0d want 0/0", det_chunk_data[31:0], chunks_issued); end
      checks++; if (nal_start_out !== 1'b0 || nal_end_out !== 1'b0 || nal_stream_id !== 2'd0 || grant_id !== 2'd0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_tags: got s=%b e=%b id=%0d grant=%0d err=%b want all 0", nal_start_out, nal_end_out, nal_stream_id, grant_id, timeout_err); end
      reset_n       = 1'b1;
      det_nal_start = 1'b0;
      det_nal_end   = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_ready: got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      checks++; if (grant_id !== 2'd0 || det_chunk_valid !== 1'b1) begin failures++; $display("FAIL rst_first_grant: got grant=%0d valid=%b want 0/1", grant_id, det_chunk_valid); end
   endtask

   task automatic test_counter_wrap();
      bit ok;
      do_reset();
      force dut.chunks_issued_reg = 16'hFFFF;
      tick();
      release dut.chunks_issued_reg;
      checks++; if (chunks_issued !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset: got %h want ffff", chunks_issued); end
      req_valid = 4'b0001;
      wait_issue(ok);
      checks++; if (!ok) begin failures++; $display("FAIL wrap_issue: got no det_chunk_valid want pulse"); end
      req_valid = 4'b0000;
      tick();
      checks++; if (chunks_issued !== 16'd0) begin failures++; $display("FAIL wrap_zero: got %0d want 0", chunks_issued); end
      det_done = 1'b1;
      tick();
      det_done  = 1'b0;
      req_valid = 4'b0001;
      wait_issue(ok);
      req_valid = 4'b0000;
      tick();
      checks++; if (!ok || chunks_issued !== 16'd1) begin failures++; $display("FAIL wrap_next: got %0d want 1", chunks_issued); end
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = '0;
      det_done      = 1'b0;
      det_nal_start = 1'b0;
      det_nal_end   = 1'b0;
      for (int s = 0; s < N; s++) req_chunk[s*CW +: CW] = pat(s);
      tick();
      test_reset();
      test_single();
      test_round_robin();
      test_tagging();
      test_watchdog();
      test_reset_mid_wait();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got simulation still running want finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
